// File: rtl/sdio_spi_ctrl_if.sv
// CPU bus, SD socket and SPI pins of the SDIO card controller, bundled as one interface.
// master: bus/socket side driving the controller; slave: the controller itself.
interface sdio_spi_ctrl_if;
    logic       AS_CPU_n;
    logic       DS_n;
    logic       RW_n;
    logic [7:0] A_HIGH;
    logic [5:0] A_LOW;
    logic [7:0] BASE_SDIO;
    logic       SDIO_CONFIGURED_n;
    logic [7:0] D_IN;
    logic [7:0] D_OUT;
    logic       D_OE;
    logic       SPI_SCK;
    logic       SPI_MOSI;
    logic       SPI_MISO;
    logic       SPI_CS_n;
    logic       CARD_DET_n;

    modport master (
        output AS_CPU_n, DS_n, RW_n, A_HIGH, A_LOW, BASE_SDIO, SDIO_CONFIGURED_n,
        output D_IN, SPI_MISO, CARD_DET_n,
        input  D_OUT, D_OE, SPI_SCK, SPI_MOSI, SPI_CS_n
    );

    modport slave (
        input  AS_CPU_n, DS_n, RW_n, A_HIGH, A_LOW, BASE_SDIO, SDIO_CONFIGURED_n,
        input  D_IN, SPI_MISO, CARD_DET_n,
        output D_OUT, D_OE, SPI_SCK, SPI_MOSI, SPI_CS_n
    );
endinterface

// File: rtl/sdio_spi_ctrl.sv
// Zorro II register front-end (DATA, CTRL/STATUS, DIVIDER) plus byte-wide SPI mode-0 engine.
// Reads registered one clock after DS; a byte transfer keeps BUSY for 16*(DIV+1) clocks, writes while BUSY set OVR.
module sdio_spi_ctrl #(
    parameter int DIV_RESET = 8,
    parameter int DIV_WIDTH = 8
) (
    input  logic          C7M,
    input  logic          RESET,
    sdio_spi_ctrl_if.slave bus
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t               state, state_nxt;
    logic                 sel, acc, act, done;
    logic                 wr_act, rd_act, start;
    logic [1:0]           rsel;
    logic [DIV_WIDTH-1:0] div, div_cnt;
    logic [7:0]           tx_shift, rx_shift, data_reg, rd_val, d_out;
    logic [2:0]           bit_cnt;
    logic                 sck, busy, ovr, ovr_hold, cs_bit;
    logic                 tick, last;

    assign sel    = !bus.SDIO_CONFIGURED_n && !bus.AS_CPU_n && (bus.A_HIGH == bus.BASE_SDIO);
    assign acc    = sel && !bus.DS_n;
    assign act    = acc && !done;
    assign rsel   = bus.A_LOW[1:0];
    assign wr_act = act && !bus.RW_n;
    assign rd_act = act && bus.RW_n;
    assign busy   = (state == XFER);
    assign start  = wr_act && (rsel == 2'd0) && !busy;
    assign tick   = busy && (div_cnt == '0);
    assign last   = tick && sck && (bit_cnt == 3'd7);

    assign bus.D_OE     = sel && bus.RW_n && !bus.DS_n;
    assign bus.D_OUT    = d_out;
    assign bus.SPI_SCK  = sck;
    assign bus.SPI_MOSI = busy ? tx_shift[7] : 1'b1;
    assign bus.SPI_CS_n = !cs_bit;

    // ovr_hold keeps the pre-clear OVR visible for the rest of the STATUS read cycle
    always_comb begin
        rd_val = 8'hFF;
        case (rsel)
            2'd0:    rd_val = data_reg;
            2'd1:    rd_val = {busy, ovr | ovr_hold, !bus.CARD_DET_n, 4'b0000, cs_bit};
            2'd2:    rd_val = 8'(div);
            default: rd_val = 8'hFF;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = XFER;
            XFER:    if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge C7M or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge C7M or posedge RESET) begin
        if (RESET) begin
            done     <= 1'b0;
            ovr      <= 1'b0;
            ovr_hold <= 1'b0;
            cs_bit   <= 1'b0;
            div      <= DIV_WIDTH'(DIV_RESET);
            d_out    <= 8'hFF;
            data_reg <= 8'hFF;
        end else begin
            if (bus.AS_CPU_n)  done <= 1'b0;
            else if (acc)      done <= 1'b1;

            if (bus.AS_CPU_n)                      ovr_hold <= 1'b0;
            else if (rd_act && (rsel == 2'd1))     ovr_hold <= ovr;

            if (acc) d_out <= rd_val;

            // BUSY here is the pre-update value, so a write on the final cycle still overruns
            if (wr_act && (rsel != 2'd3)) begin
                if (busy) begin
                    ovr <= 1'b1;
                end else begin
                    case (rsel)
                        2'd1:    cs_bit <= bus.D_IN[0];
                        2'd2:    div    <= DIV_WIDTH'(bus.D_IN);
                        default: ;
                    endcase
                end
            end else if (rd_act && (rsel == 2'd1)) begin
                ovr <= 1'b0;
            end

            if (last) data_reg <= rx_shift;
        end
    end

    always_ff @(posedge C7M or posedge RESET) begin
        if (RESET) begin
            sck      <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= 3'd0;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
        end else if (start) begin
            sck      <= 1'b0;
            div_cnt  <= div;
            bit_cnt  <= 3'd0;
            tx_shift <= bus.D_IN;
        end else if (busy) begin
            if (tick) begin
                div_cnt <= div;
                sck     <= !sck;
                if (!sck) begin
                    rx_shift <= {rx_shift[6:0], bus.SPI_MISO};
                end else begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                    bit_cnt  <= bit_cnt + 3'd1;
                end
            end else begin
                div_cnt <= div_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdio_spi_ctrl.sv
// Randomized scoreboard bench for sdio_spi_ctrl: a cycle-indexed register model predicts reads and SPI bytes.
module tb_sdio_spi_ctrl;

    logic C7M   = 1'b0;
    logic RESET = 1'b0;

    sdio_spi_ctrl_if bus();

    sdio_spi_ctrl #(.DIV_RESET(8), .DIV_WIDTH(8)) dut (
        .C7M   (C7M),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 C7M = ~C7M;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge C7M) cyc <= cyc + 1;

    // reference model, indexed by clock-edge number
    int         m_div, m_start, m_end;
    bit         m_cs, m_ovr, m_active;
    logic [7:0] m_data, m_rx;
    bit         card;
    int         miso_mode;   // 0 loopback, 1 tied low, 2 pattern
    logic [7:0] pat;

    logic [7:0] rd_q[$];
    string      rd_n[$];
    logic [7:0] spi_tx_q[$];
    int         spi_hp_q[$];

    int         nrise = 0;
    int         nedge = 0;
    int         hp_cnt = 0;
    bit         hp_bad = 0;
    bit         prev_sck = 0;
    logic [7:0] bits = 8'h00;
    bit         prev_oe = 0;
    logic [7:0] last_do = 8'h00;

    assign bus.SPI_MISO = (miso_mode == 0) ? bus.SPI_MOSI :
                          (miso_mode == 1) ? 1'b0 : pat[3'(7 - nrise)];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic bit m_busy(input int p);
        return m_active && (p > m_start) && (p <= m_end);
    endfunction

    task automatic m_retire(input int p);
        if (m_active && p > m_end) begin
            m_data   = m_rx;
            m_active = 0;
        end
    endtask

    task automatic m_reset();
        m_div = 8; m_cs = 0; m_ovr = 0; m_active = 0; m_data = 8'hFF;
    endtask

    // read monitor: compares the last D_OUT seen while D_OE was high
    always @(posedge C7M) begin
        #2;
        if (RESET) begin
            prev_oe = 0;
        end else begin
            if (bus.D_OE) begin
                last_do = bus.D_OUT;
            end else if (prev_oe) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rd_unexpected: got %0h with no read expected", last_do);
                end else begin
                    check(rd_n.pop_front(), 32'(last_do), 32'(rd_q.pop_front()));
                end
            end
            prev_oe = bus.D_OE;
        end
    end

    // SPI monitor: collects MOSI on SCK rises, checks each half-period
    always @(posedge C7M) begin
        #2;
        if (RESET) begin
            nrise = 0; nedge = 0; hp_cnt = 0; hp_bad = 0; prev_sck = 0;
        end else begin
            hp_cnt++;
            if (bus.SPI_SCK !== prev_sck) begin
                if (nedge > 0 && (spi_hp_q.size() == 0 || hp_cnt != spi_hp_q[0])) hp_bad = 1;
                hp_cnt = 0;
                nedge++;
                prev_sck = bus.SPI_SCK;
                if (bus.SPI_SCK) begin
                    bits = {bits[6:0], bus.SPI_MOSI};
                    nrise++;
                end else if (nrise == 8) begin
                    if (spi_tx_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL spi_unexpected: byte %0h with no transfer expected", bits);
                    end else begin
                        check("spi_mosi", 32'(bits), 32'(spi_tx_q.pop_front()));
                        check("spi_halfper_ok", 32'(hp_bad), 32'd0);
                        void'(spi_hp_q.pop_front());
                    end
                    nrise = 0; nedge = 0; hp_bad = 0;
                end
            end
        end
    end

    // called and returns on a falling edge; the action lands on the next rising edge
    task automatic bus_acc(input bit rd, input logic [1:0] r, input logic [7:0] d,
                           input int n, input string name);
        int a, e;
        bit be;
        logic [7:0] ex;
        a = cyc + 1;
        e = a + n - 1;
        m_retire(a);
        if (!rd) begin
            if (r != 2'd3) begin
                if (m_busy(a)) m_ovr = 1;
                else if (r == 2'd0) begin
                    m_active = 1; m_start = a; m_end = a + 16 * (m_div + 1);
                    m_rx = (miso_mode == 0) ? d : (miso_mode == 1) ? 8'h00 : pat;
                    spi_tx_q.push_back(d);
                    spi_hp_q.push_back(m_div + 1);
                end
                else if (r == 2'd1) m_cs = d[0];
                else m_div = int'(d);
            end
        end else begin
            be = m_busy(e);
            m_retire(e);
            case (r)
                2'd0:    ex = m_data;
                2'd1:    begin ex = {be, m_ovr, card, 4'b0000, m_cs}; m_ovr = 0; end
                2'd2:    ex = 8'(m_div);
                default: ex = 8'hFF;
            endcase
            rd_q.push_back(ex);
            rd_n.push_back(name);
        end
        bus.RW_n = rd; bus.A_LOW = {4'($urandom), r}; bus.D_IN = d;
        bus.AS_CPU_n = 0; bus.DS_n = 0;
        repeat (n) @(negedge C7M);
        bus.AS_CPU_n = 1; bus.DS_n = 1; bus.RW_n = 1;
        @(negedge C7M);
    endtask

    task automatic bus_nosel(input bit cfg_n, input logic [7:0] ah, input bit rd,
                             input logic [1:0] r, input logic [7:0] d);
        bus.SDIO_CONFIGURED_n = cfg_n; bus.A_HIGH = ah;
        bus.RW_n = rd; bus.A_LOW = {4'b0000, r}; bus.D_IN = d;
        bus.AS_CPU_n = 0; bus.DS_n = 0;
        repeat (3) begin
            @(negedge C7M);
            check("doe_unsel", 32'(bus.D_OE), 32'd0);
        end
        bus.AS_CPU_n = 1; bus.DS_n = 1; bus.RW_n = 1;
        bus.SDIO_CONFIGURED_n = 0; bus.A_HIGH = 8'hE9;
        @(negedge C7M);
    endtask

    task automatic wait_done();
        int guard = 0;
        while (m_active && cyc <= m_end + 1 && guard < 5000) begin
            @(negedge C7M);
            guard++;
        end
    endtask

    task automatic do_reset();
        RESET = 1;
        #1;
        check("rst_sck",  32'(bus.SPI_SCK),  32'd0);
        check("rst_cs_n", 32'(bus.SPI_CS_n), 32'd1);
        check("rst_mosi", 32'(bus.SPI_MOSI), 32'd1);
        check("rst_dout", 32'(bus.D_OUT),    32'hFF);
        spi_tx_q.delete();
        spi_hp_q.delete();
        m_reset();
        @(negedge C7M);
        RESET = 0;
        @(negedge C7M);
    endtask

    task automatic set_card(input bit c);
        card = c;
        bus.CARD_DET_n = !c;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.AS_CPU_n = 1; bus.DS_n = 1; bus.RW_n = 1;
        bus.A_HIGH = 8'hE9; bus.A_LOW = 6'd0; bus.BASE_SDIO = 8'hE9;
        bus.SDIO_CONFIGURED_n = 0; bus.D_IN = 8'h00;
        miso_mode = 0; pat = 8'h00;
        set_card(0);
        m_reset();
        @(negedge C7M);
        do_reset();

        bus_acc(1, 2'd1, 8'h00, 1, "st_rst_nocard");
        set_card(1);
        bus_acc(1, 2'd1, 8'h00, 1, "st_rst_card");
        bus_acc(1, 2'd2, 8'h00, 1, "div_rst");
        bus_acc(1, 2'd3, 8'h00, 1, "reg3_read");

        // DIV=0 loopback, BUSY sampled on its last cycle then clear
        bus_acc(0, 2'd2, 8'h00, 1, "w");
        bus_acc(0, 2'd1, 8'h01, 1, "w");
        check("cs_asserted", 32'(bus.SPI_CS_n), 32'd0);
        miso_mode = 0;
        bus_acc(0, 2'd0, 8'hA5, 1, "w");
        repeat (14) @(negedge C7M);
        bus_acc(1, 2'd1, 8'h00, 1, "st_busy_last_div0");
        bus_acc(1, 2'd1, 8'h00, 1, "st_idle_div0");
        bus_acc(1, 2'd0, 8'h00, 1, "data_loop_a5");

        // DIV=3, MISO low
        bus_acc(0, 2'd2, 8'h03, 1, "w");
        miso_mode = 1;
        bus_acc(0, 2'd0, 8'h3C, 1, "w");
        repeat (62) @(negedge C7M);
        bus_acc(1, 2'd1, 8'h00, 1, "st_busy_last_div3");
        bus_acc(1, 2'd1, 8'h00, 1, "st_idle_div3");
        bus_acc(1, 2'd0, 8'h00, 1, "data_zero");

        // DIV=0, first cycle after BUSY ends
        bus_acc(0, 2'd2, 8'h00, 1, "w");
        miso_mode = 2; pat = 8'h6D;
        bus_acc(0, 2'd0, 8'h81, 1, "w");
        repeat (15) @(negedge C7M);
        bus_acc(1, 2'd1, 8'h00, 1, "st_idle_k17");
        bus_acc(1, 2'd0, 8'h00, 1, "data_pattern");

        // overrun while busy, OVR survives a long STATUS read then clears
        set_card(0);
        bus_acc(0, 2'd2, 8'h03, 1, "w");
        miso_mode = 0;
        bus_acc(0, 2'd0, 8'h55, 1, "w");
        repeat (4) @(negedge C7M);
        bus_acc(0, 2'd0, 8'hF0, 1, "w");
        bus_acc(1, 2'd1, 8'h00, 4, "st_ovr_busy");
        wait_done();
        bus_acc(1, 2'd1, 8'h00, 1, "st_ovr_cleared");
        bus_acc(1, 2'd0, 8'h00, 1, "data_after_ovr");

        // write on the very cycle BUSY clears
        bus_acc(0, 2'd2, 8'h00, 1, "w");
        bus_acc(0, 2'd0, 8'h3A, 1, "w");
        repeat (14) @(negedge C7M);
        bus_acc(0, 2'd1, 8'h00, 1, "w");
        bus_acc(1, 2'd1, 8'h00, 1, "st_ovr_edge");
        bus_acc(1, 2'd0, 8'h00, 1, "data_edge");

        // no decode when unconfigured or off-base
        bus_nosel(1, 8'hE9, 0, 2'd2, 8'h77);
        bus_nosel(0, 8'h12, 0, 2'd0, 8'h99);
        bus_nosel(1, 8'hE9, 1, 2'd1, 8'h00);
        bus_nosel(0, 8'hEA, 1, 2'd0, 8'h00);
        bus_acc(1, 2'd2, 8'h00, 1, "div_unsel");

        // one long bus cycle, one transfer
        bus_acc(0, 2'd2, 8'h01, 1, "w");
        bus_acc(0, 2'd0, 8'hC3, 4, "w");
        wait_done();
        bus_acc(1, 2'd1, 8'h00, 1, "st_single_xfer");
        bus_acc(1, 2'd0, 8'h00, 1, "data_single_xfer");

        // reset in bit 4 of a transfer
        set_card(1);
        bus_acc(0, 2'd2, 8'h03, 1, "w");
        bus_acc(0, 2'd0, 8'h96, 1, "w");
        repeat (34) @(negedge C7M);
        do_reset();
        bus_acc(1, 2'd2, 8'h00, 1, "div_after_reset");
        bus_acc(1, 2'd1, 8'h00, 1, "st_after_reset");
        bus_acc(1, 2'd0, 8'h00, 1, "data_after_reset");

        for (int i = 0; i < 24; i++) begin
            set_card(1'($urandom_range(0, 1)));
            miso_mode = $urandom_range(0, 2);
            pat = 8'($urandom);
            bus_acc(0, 2'd2, 8'($urandom_range(0, 3)), 1, "w");
            if ($urandom_range(0, 1) == 1) bus_acc(0, 2'd1, 8'($urandom), $urandom_range(1, 2), "w");
            bus_acc(0, 2'd0, 8'($urandom), $urandom_range(1, 3), "w");
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 8)) @(negedge C7M);
                bus_acc(0, 2'($urandom_range(0, 2)), 8'($urandom), 1, "w");
            end
            bus_acc(1, 2'd1, 8'h00, $urandom_range(1, 4), "rnd_status_busy");
            wait_done();
            bus_acc(1, 2'd1, 8'h00, 1, "rnd_status");
            bus_acc(1, 2'd0, 8'h00, 1, "rnd_data");
            bus_acc(1, 2'd2, 8'h00, 1, "rnd_div");
            if ($urandom_range(0, 3) == 0) bus_acc(1, 2'd3, 8'h00, 1, "rnd_reg3");
        end

        repeat (20) @(negedge C7M);
        check("rd_q_drained",  32'(rd_q.size()),     32'd0);
        check("spi_q_drained", 32'(spi_tx_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdio_spi_ctrl.md
Name: sdio_spi_ctrl

Overview:
- Sequences the SF2000 SD-card interface behind the SDIO AutoConfig board (5194/11, 64K I/O space).
- Decodes CPU Zorro II cycles against the assigned SDIO base and exposes a three-register interface: DATA, CTRL/STATUS and DIVIDER.
- Runs a byte-wide SPI mode-0 shift engine with a programmable SCK divider, a chip-select line and a busy/overrun handshake to the driver.

Parameters:
- DIV_RESET, 8, SCK divider value after reset: 7.09 MHz/(2*(8+1)) = 394 kHz, which meets the SD init limit of 400 kHz or less.
- DIV_WIDTH, 8, width of the divider register and the divider counter.

Ports:
- C7M  in  1  system clock (7M).
- RESET  in  1  asynchronous reset, active-high.
- AS_CPU_n  in  1  CPU address strobe.
- DS_n  in  1  data strobe.
- RW_n  in  1  1 = read, 0 = write.
- A_HIGH  in  8  address bits A23..A16.
- A_LOW  in  6  address bits A6..A1.
- BASE_SDIO  in  8  base address A23..A16 assigned by AutoConfig.
- SDIO_CONFIGURED_n  in  1  low once the board is configured.
- D_IN  in  8  CPU write data, D15..D8.
- D_OUT  out  8  CPU read data, D15..D8.
- D_OE  out  1  data-bus output enable.
- SPI_SCK  out  1  SD clock.
- SPI_MOSI  out  1  SD command/data in.
- SPI_MISO  in  1  SD data out.
- SPI_CS_n  out  1  SD chip select.
- CARD_DET_n  in  1  socket card-detect, low = card present.

Behaviour:
- Decode:
  - sel = !SDIO_CONFIGURED_n && !AS_CPU_n && (A_HIGH == BASE_SDIO).
  - D_OE = sel && RW_n && !DS_n, combinational. All other bits in the 64K space alias the registers.
- Register select by A_LOW[2:1]:
  - 0 DATA
  - 1 CTRL/STATUS
  - 2 DIVIDER
  - 3 reads 0xFF, writes ignored
- Access strobe:
  - acc = sel && !DS_n sampled on posedge C7M.
  - Actions fire on the first acc cycle only. A done flag is set on that cycle and cleared while AS_CPU_n is high, giving exactly one action per bus cycle.
- Reads: D_OUT is registered every acc cycle.
  - DATA: last received byte.
  - STATUS: [7] BUSY, [6] OVR, [5] !CARD_DET_n, [4:1] 0, [0] CS bit.
  - DIVIDER: current divider value.
  - A STATUS read clears OVR on its action cycle; the value returned is the pre-clear value.
- Writes:
  - DATA while idle starts a transfer. CTRL writes the CS bit from D_IN[8]. DIVIDER loads D_IN.
  - Any of these writes while BUSY is ignored and sets OVR.
  - SPI_CS_n = !CS bit.
- SPI engine: states IDLE, XFER.
  - Start: on the action cycle, load tx_shift = D_IN, bit_cnt = 0, div_cnt = DIV. The next cycle shows BUSY = 1, SPI_MOSI = D_IN[15], SPI_SCK = 0.
  - div_cnt decrements each cycle. At 0 it reloads DIV and SCK toggles.
  - Rising edge: shift SPI_MISO (sampled that cycle) into rx_shift LSB.
  - Falling edge: shift tx left so MOSI presents the next bit, then bit_cnt++.
  - On the 8th falling edge: DATA = rx_shift, BUSY clears, state returns to IDLE, SCK stays low.
  - BUSY is high for exactly 16*(DIV+1) cycles.
  - MOSI idles high when no transfer is running.
- Reset values (async):
  - Outputs: D_OUT = 0xFF, SPI_SCK = 0, SPI_MOSI = 1, SPI_CS_n = 1.
  - Internal: BUSY = 0, OVR = 0, CS bit = 0, DATA = 0xFF, DIV = DIV_RESET, state IDLE, done flag clear.
- Boundaries:
  - Reset mid-transfer aborts immediately: SCK goes low and CS deasserts.
  - DIV = 0 gives SCK = C7M/2.
  - A write that coincides with the cycle BUSY clears is still ignored and sets OVR, since BUSY is sampled pre-update.
  - Unconfigured board: no decode, D_OE = 0.
  - Card removal does not abort a transfer; it is reported in STATUS only.

Test Plan:
- Reset -> SPI_CS_n = 1, SPI_SCK = 0, SPI_MOSI = 1, STATUS read = 0x00 (no card) or 0x20 (card), DIVIDER read = 0x08.
- BASE_SDIO = 0xE9, configured. Write DIVIDER = 0, CTRL = 0x01, then DATA = 0xA5 with MISO looped to MOSI -> SPI_CS_n = 0, BUSY high exactly 16 cycles, 8 SCK pulses, MOSI sequence 1,0,1,0,0,1,0,1, DATA read = 0xA5.
- DIV = 3, write DATA = 0x3C with MISO tied 0 -> SCK half-period 4 cycles, BUSY for 64 cycles, DATA = 0x00.
- Write DATA 0x55 again while BUSY -> transfer completes unchanged. STATUS = 0xC1 while busy, next STATUS read = 0x01 (OVR cleared).
- SDIO_CONFIGURED_n = 1, or A_HIGH != BASE_SDIO -> D_OE stays 0, writes have no effect. A single bus cycle holding DS_n low for 4 clocks starts exactly one transfer.
- Assert RESET at bit 4 of a transfer -> SCK = 0, SPI_CS_n = 1, BUSY = 0, DIV = 8 within the same cycle.
